// File: rtl/alu_unit.sv
// 8-bit 6502 ALU: one-hot selects, result/flags captured in the adder-hold register one cycle after the select, with tri-state ADL/SB bus drive.
// Define ALU_DECIMAL_EN to compile in BCD add/subtract under dec_en; without it all arithmetic is binary.
module alu_unit (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       sums,
  input  logic       subs,
  input  logic       ands,
  input  logic       eors,
  input  logic       ors,
  input  logic       shftr,
  input  logic       shftcr,
  input  logic       dec_en,
  input  logic       adl_oe,
  input  logic       sb_oe,
  output tri   [7:0] adl,
  output tri   [7:0] sb,
  output logic       cout,
  output logic       zero,
  output logic       overflow,
  output logic       neg
);

  logic [7:0] hold;
  logic [7:0] res;
  logic       res_c;
  logic       res_v;
  logic       any_sel;
  logic [8:0] add9;
  logic [8:0] sub9;

  assign any_sel = sums | subs | ands | eors | ors | shftr | shftcr;
  assign add9    = {1'b0, a} + {1'b0, b} + {8'b0, cin};
  assign sub9    = {1'b0, a} + {1'b0, ~b} + {8'b0, cin};

`ifdef ALU_DECIMAL_EN
  logic [4:0] dlo;
  logic       dlo_c;
  logic [3:0] dlo_nib;
  logic [4:0] dhi;
  logic       dadd_c;
  logic [3:0] dhi_nib;
  logic [7:0] dadd_bin;
  logic       dadd_v;
  logic [7:0] dadd_r;
  logic       dsub_lo_borrow;
  logic [7:0] dsub_r;

  always_comb begin
    dlo      = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    dlo_c    = dlo > 5'd9;
    dlo_nib  = dlo[3:0] + (dlo_c ? 4'd6 : 4'd0);
    dhi      = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, dlo_c};
    // V comes from the sum before the high nibble is decimal-adjusted
    dadd_bin = {dhi[3:0], dlo_nib};
    dadd_v   = ~(a[7] ^ b[7]) & (a[7] ^ dadd_bin[7]);
    dadd_c   = dhi > 5'd9;
    dhi_nib  = dhi[3:0] + (dadd_c ? 4'd6 : 4'd0);
    dadd_r   = {dhi_nib, dlo_nib};

    dsub_lo_borrow = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'b0, ~cin});
    dsub_r = sub9[7:0] - (dsub_lo_borrow ? 8'h06 : 8'h00) - (sub9[8] ? 8'h00 : 8'h60);
  end
`else
  logic dec_unused;
  assign dec_unused = dec_en;
`endif

  always_comb begin
    res   = 8'h00;
    res_c = 1'b0;
    res_v = 1'b0;
    if (sums) begin
      res   = add9[7:0];
      res_c = add9[8];
      res_v = ~(a[7] ^ b[7]) & (a[7] ^ add9[7]);
`ifdef ALU_DECIMAL_EN
      if (dec_en) begin
        res   = dadd_r;
        res_c = dadd_c;
        res_v = dadd_v;
      end
`endif
    end else if (subs) begin
      res   = sub9[7:0];
      res_c = sub9[8];
      res_v = (a[7] ^ b[7]) & (a[7] ^ sub9[7]);
`ifdef ALU_DECIMAL_EN
      if (dec_en) begin
        res = dsub_r;
      end
`endif
    end else if (ands) begin
      res = a & b;
    end else if (eors) begin
      res = a ^ b;
    end else if (ors) begin
      res = a | b;
    end else if (shftr) begin
      res   = {1'b0, a[7:1]};
      res_c = a[0];
    end else if (shftcr) begin
      res   = {cin, a[7:1]};
      res_c = a[0];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hold     <= 8'h00;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      neg      <= 1'b0;
    end else if (any_sel) begin
      hold     <= res;
      cout     <= res_c;
      zero     <= (res == 8'h00);
      overflow <= res_v;
      neg      <= res[7];
    end
  end

  assign adl = adl_oe ? hold : 8'bz;
  assign sb  = sb_oe  ? hold : 8'bz;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed vector table, bus/reset sequences, random ops against a reference model.
module tb_alu_unit;

  localparam logic [6:0] SUMS = 7'h01, SUBS = 7'h02, ANDS = 7'h04, EORS = 7'h08,
                         ORS  = 7'h10, SHR  = 7'h20, SHCR = 7'h40;
`ifdef ALU_DECIMAL_EN
  localparam bit DEC_ON = 1'b1;
`else
  localparam bit DEC_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [6:0] sel;
    logic       dec;
    logic [7:0] r;
    logic       c, z, v, n;
  } vec_t;

  typedef struct {
    int r;
    bit c, z, v, n;
  } res_t;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] a, b;
  logic       cin, dec_en, adl_oe, sb_oe;
  logic [6:0] sel;
  logic       probe_adl, probe_sb;
  tri   [7:0] adl, sb;
  logic       cout, zero, overflow, neg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Bench-side weak-looking probe drivers: a DUT that fails to release the bus corrupts 0x5A.
  assign adl = probe_adl ? 8'h5A : 8'bz;
  assign sb  = probe_sb  ? 8'h5A : 8'bz;

  alu_unit dut (
    .clk(clk), .clr(clr), .a(a), .b(b), .cin(cin),
    .sums(sel[0]), .subs(sel[1]), .ands(sel[2]), .eors(sel[3]), .ors(sel[4]),
    .shftr(sel[5]), .shftcr(sel[6]), .dec_en(dec_en),
    .adl_oe(adl_oe), .sb_oe(sb_oe), .adl(adl), .sb(sb),
    .cout(cout), .zero(zero), .overflow(overflow), .neg(neg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] r,
                             input logic c, input logic z, input logic v, input logic n);
    check({tag, " result"},   {24'b0, sb}, {24'b0, r});
    check({tag, " cout"},     {31'b0, cout}, {31'b0, c});
    check({tag, " zero"},     {31'b0, zero}, {31'b0, z});
    check({tag, " overflow"}, {31'b0, overflow}, {31'b0, v});
    check({tag, " neg"},      {31'b0, neg}, {31'b0, n});
  endtask

  task automatic apply(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                       input logic [6:0] isel, input logic idec);
    @(negedge clk);
    a = ia; b = ib; cin = icin; sel = isel; dec_en = idec;
    @(posedge clk);
    #1 sel = 7'h00;
  endtask

  // Reference model written from the arithmetic rules, first asserted select wins.
  function automatic res_t model(input int ia, input int ib, input int icin,
                                 input logic [6:0] isel, input bit idec);
    res_t o;
    int s, lo, hi, bin;
    o = '{r: 0, c: 0, z: 0, v: 0, n: 0};
    if (isel[0]) begin
      if (idec && DEC_ON) begin
        lo = (ia % 16) + (ib % 16) + icin;
        if (lo > 9) lo += 6;
        hi = (ia / 16) + (ib / 16) + (lo > 15 ? 1 : 0);
        bin = ((hi * 16) + (lo % 16)) % 256;
        o.v = (((ia ^ ib) & 128) == 0) && (((ia ^ bin) & 128) != 0);
        if (hi > 9) hi += 6;
        o.c = hi > 15;
        o.r = ((hi * 16) + (lo % 16)) % 256;
      end else begin
        s = ia + ib + icin;
        o.r = s % 256;
        o.c = s > 255;
        o.v = (((ia ^ ib) & 128) == 0) && (((ia ^ o.r) & 128) != 0);
      end
    end else if (isel[1]) begin
      s = ia - ib - (1 - icin);
      o.c = s >= 0;
      o.r = s & 255;
      o.v = (((ia ^ ib) & 128) != 0) && (((ia ^ o.r) & 128) != 0);
      if (idec && DEC_ON) begin
        if ((ia % 16) - (ib % 16) - (1 - icin) < 0) o.r = o.r - 6;
        if (!o.c) o.r = o.r - 96;
        o.r = o.r & 255;
      end
    end else if (isel[2]) o.r = ia & ib;
    else if (isel[3]) o.r = ia ^ ib;
    else if (isel[4]) o.r = ia | ib;
    else if (isel[5]) begin o.r = ia / 2; o.c = (ia % 2) == 1; end
    else if (isel[6]) begin o.r = ia / 2 + 128 * icin; o.c = (ia % 2) == 1; end
    o.z = o.r == 0;
    o.n = o.r >= 128;
    return o;
  endfunction

  vec_t vt[$];
  res_t exp_s, m;

  initial begin
    clr = 1'b1; a = 8'h00; b = 8'h00; cin = 1'b0; sel = 7'h00; dec_en = 1'b0;
    adl_oe = 1'b0; sb_oe = 1'b1; probe_adl = 1'b1; probe_sb = 1'b0;

    vt.push_back('{8'h05, 8'h0F, 1'b0, SUMS, 1'b0, 8'h14, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'h50, 8'hB0, 1'b1, SUBS, 1'b0, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b1});
    vt.push_back('{8'h81, 8'h00, 1'b1, SHCR, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1});
    vt.push_back('{8'h81, 8'h00, 1'b1, SHR,  1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'hFF, 8'h01, 1'b0, SUMS, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    vt.push_back('{8'h7F, 8'h01, 1'b0, SUMS, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1});
    vt.push_back('{8'hF0, 8'h3C, 1'b1, ANDS, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'hF0, 8'h3C, 1'b1, EORS, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{8'h00, 8'h00, 1'b1, ORS,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    vt.push_back('{8'h10, 8'h01, 1'b0, SUMS | SUBS, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'hF0, 8'h0F, 1'b0, ANDS | ORS, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    vt.push_back('{8'h00, 8'h00, 1'b0, SUBS, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
    vt.push_back('{8'h99, 8'h0F, 1'b0, ANDS, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef ALU_DECIMAL_EN
    vt.push_back('{8'h99, 8'h01, 1'b0, SUMS, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    vt.push_back('{8'h09, 8'h01, 1'b0, SUMS, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'h10, 8'h01, 1'b1, SUBS, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'h00, 8'h01, 1'b1, SUBS, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1});
`else
    vt.push_back('{8'h09, 8'h01, 1'b0, SUMS, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{8'h10, 8'h01, 1'b1, SUBS, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0});
`endif

    #12;
    check_state("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b0;

    foreach (vt[i]) begin
      apply(vt[i].a, vt[i].b, vt[i].cin, vt[i].sel, vt[i].dec);
      check_state($sformatf("vec%0d", i), vt[i].r, vt[i].c, vt[i].z, vt[i].v, vt[i].n);
    end

    // Bus drive: hold is 0xA0 after this subtract.
    apply(8'h50, 8'hB0, 1'b1, SUBS, 1'b0);
    sb_oe = 1'b0; adl_oe = 1'b0; probe_sb = 1'b1; probe_adl = 1'b1;
    #1;
    check("adl released", {24'b0, adl}, 32'h5A);
    check("sb released", {24'b0, sb}, 32'h5A);
    adl_oe = 1'b1; probe_adl = 1'b0;
    #1;
    check("adl driven", {24'b0, adl}, 32'hA0);
    check("sb still released", {24'b0, sb}, 32'h5A);
    sb_oe = 1'b1; probe_sb = 1'b0;
    #1;
    check("both adl", {24'b0, adl}, 32'hA0);
    check("both sb", {24'b0, sb}, 32'hA0);
    adl_oe = 1'b0; probe_adl = 1'b1;

    apply(8'hFF, 8'hFF, 1'b1, 7'h00, 1'b0);
    check_state("no select", 8'hA0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Operand changes late in the cycle: the value at the edge is captured.
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; dec_en = 1'b0; sel = SUMS;
    #3 a = 8'h02;
    @(posedge clk);
    #1 sel = 7'h00;
    check("late operand", {24'b0, sb}, 32'h03);

    // Asynchronous clear between edges, then a select held during clear.
    apply(8'h50, 8'hB0, 1'b1, SUBS, 1'b0);
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check_state("async clr", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    a = 8'h05; b = 8'h0F; sel = SUMS;
    @(posedge clk);
    #1;
    check_state("select in clr", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sel = 7'h00;
    @(negedge clk);
    clr = 1'b0;

    exp_s = '{r: 0, c: 0, z: 0, v: 0, n: 0};
    for (int it = 0; it < 400; it++) begin
      logic [7:0] ra, rb;
      logic       rc, rd;
      logic [6:0] rs;
      int         pick;
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rd = 1'($urandom);
      pick = $urandom_range(0, 8);
      rs = (pick < 7) ? 7'(1 << pick) : 7'h00;
      if ($urandom_range(0, 3) == 0) rs = rs | 7'($urandom);
      apply(ra, rb, rc, rs, rd);
      if (rs != 7'h00) begin
        m = model(int'(ra), int'(rb), int'(rc), rs, rd);
        exp_s = m;
      end
      check_state($sformatf("rand%0d a=%0h b=%0h c=%0d sel=%0h d=%0d", it, ra, rb, rc, rs, rd),
                  8'(exp_s.r), exp_s.c, exp_s.z, exp_s.v, exp_s.n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
